// File: rtl/lsu_axi_ctrl.sv
// Load/store unit bridging the MEM stage to an AXI4-Lite-style master port.
// Single outstanding transaction; every bus-facing output is registered.
module lsu_axi_ctrl #(
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          req_valid_i,
  output logic                          req_ready_o,
  input  logic                          req_we_i,
  input  logic [1:0]                    req_size_i,
  input  logic                          req_unsigned_i,
  input  logic [AXI_ADDR_WIDTH-1:0]     req_addr_i,
  input  logic [AXI_DATA_WIDTH-1:0]     req_wdata_i,
  input  logic [REG_ADDR_WIDTH-1:0]     req_rd_i,
  output logic                          resp_valid_o,
  output logic                          resp_we_o,
  output logic [REG_ADDR_WIDTH-1:0]     resp_rd_o,
  output logic [AXI_DATA_WIDTH-1:0]     resp_rdata_o,
  output logic                          resp_err_o,
  output logic                          busy_o,
  output logic                          aw_valid_o,
  input  logic                          aw_ready_i,
  output logic [AXI_ADDR_WIDTH-1:0]     aw_addr_o,
  output logic                          w_valid_o,
  input  logic                          w_ready_i,
  output logic [AXI_DATA_WIDTH-1:0]     w_data_o,
  output logic [AXI_DATA_WIDTH/8-1:0]   w_strb_o,
  input  logic                          b_valid_i,
  output logic                          b_ready_o,
  input  logic [1:0]                    b_resp_i,
  output logic                          ar_valid_o,
  input  logic                          ar_ready_i,
  output logic [AXI_ADDR_WIDTH-1:0]     ar_addr_o,
  input  logic                          r_valid_i,
  output logic                          r_ready_o,
  input  logic [AXI_DATA_WIDTH-1:0]     r_data_i,
  input  logic [1:0]                    r_resp_i
);

  localparam int StrbW = AXI_DATA_WIDTH / 8;
  localparam int OffW  = $clog2(StrbW);

  typedef enum logic [2:0] {IDLE, WRITE, WRESP, RADDR, RDATA, ERR, RESP} state_t;

  state_t state_q, state_d;

  logic                      reqReady_q, reqReady_d;
  logic                      awValid_q, awValid_d;
  logic                      wValid_q, wValid_d;
  logic                      bReady_q, bReady_d;
  logic                      arValid_q, arValid_d;
  logic                      rReady_q, rReady_d;
  logic [AXI_ADDR_WIDTH-1:0] awAddr_q, awAddr_d;
  logic [AXI_ADDR_WIDTH-1:0] arAddr_q, arAddr_d;
  logic [AXI_DATA_WIDTH-1:0] wData_q, wData_d;
  logic [StrbW-1:0]          wStrb_q, wStrb_d;
  logic [1:0]                size_q, size_d;
  logic                      isUnsigned_q, isUnsigned_d;
  logic [OffW-1:0]           offset_q, offset_d;
  logic [REG_ADDR_WIDTH-1:0] rd_q, rd_d;
  logic                      respValid_q, respValid_d;
  logic                      respWe_q, respWe_d;
  logic                      respErr_q, respErr_d;
  logic [AXI_DATA_WIDTH-1:0] respRdata_q, respRdata_d;
  logic [REG_ADDR_WIDTH-1:0] respRd_q, respRd_d;

  logic [OffW-1:0]           reqOffset;
  logic [2:0]                alignMask;
  logic                      reqBad;
  logic [7:0]                strbByte;
  logic [AXI_ADDR_WIDTH-1:0] alignedAddr;
  logic [AXI_DATA_WIDTH-1:0] loadShifted;
  logic [AXI_DATA_WIDTH-1:0] loadMask;
  logic                      loadSign;
  logic [AXI_DATA_WIDTH-1:0] loadData;

  // Request decode: alignment check, strobe pattern and bus-aligned address.
  always_comb begin
    reqOffset   = req_addr_i[OffW-1:0];
    alignMask   = 3'((4'd1 << req_size_i) - 4'd1);
    reqBad      = (|(req_addr_i[2:0] & alignMask)) ||
                  ((req_size_i == 2'd3) && (AXI_DATA_WIDTH == 32));
    strbByte    = 8'((9'd1 << (4'd1 << req_size_i)) - 9'd1);
    alignedAddr = {req_addr_i[AXI_ADDR_WIDTH-1:OffW], {OffW{1'b0}}};
  end

  // Load path: bring the addressed lane down to bit 0, then truncate and extend.
  always_comb begin
    loadShifted = r_data_i >> {offset_q, 3'b000};
    loadMask    = '1;
    loadSign    = loadShifted[AXI_DATA_WIDTH-1];
    case (size_q)
      2'd0: begin
        loadMask = AXI_DATA_WIDTH'(8'hFF);
        loadSign = loadShifted[7];
      end
      2'd1: begin
        loadMask = AXI_DATA_WIDTH'(16'hFFFF);
        loadSign = loadShifted[15];
      end
      2'd2: begin
        loadMask = AXI_DATA_WIDTH'(32'hFFFF_FFFF);
        loadSign = loadShifted[31];
      end
      default: ;
    endcase
    loadData = (loadShifted & loadMask) |
               ((!isUnsigned_q && loadSign) ? ~loadMask : '0);
  end

  always_comb begin
    state_d      = state_q;
    awValid_d    = awValid_q;
    wValid_d     = wValid_q;
    bReady_d     = bReady_q;
    arValid_d    = arValid_q;
    rReady_d     = rReady_q;
    awAddr_d     = awAddr_q;
    arAddr_d     = arAddr_q;
    wData_d      = wData_q;
    wStrb_d      = wStrb_q;
    size_d       = size_q;
    isUnsigned_d = isUnsigned_q;
    offset_d     = offset_q;
    rd_d         = rd_q;
    respValid_d  = 1'b0;
    respWe_d     = 1'b0;
    respErr_d    = 1'b0;
    respRdata_d  = '0;
    respRd_d     = '0;

    case (state_q)
      IDLE: begin
        if (req_valid_i && reqReady_q) begin
          size_d       = req_size_i;
          isUnsigned_d = req_unsigned_i;
          offset_d     = reqOffset;
          rd_d         = req_rd_i;
          if (reqBad) begin
            state_d = ERR;
          end else if (req_we_i) begin
            state_d   = WRITE;
            awValid_d = 1'b1;
            wValid_d  = 1'b1;
            awAddr_d  = alignedAddr;
            wData_d   = req_wdata_i << {reqOffset, 3'b000};
            wStrb_d   = StrbW'(strbByte) << reqOffset;
          end else begin
            state_d   = RADDR;
            arValid_d = 1'b1;
            arAddr_d  = alignedAddr;
          end
        end
      end
      WRITE: begin
        // AW and W complete independently; leave once neither is outstanding.
        if (awValid_q && aw_ready_i) awValid_d = 1'b0;
        if (wValid_q && w_ready_i) wValid_d = 1'b0;
        if ((!awValid_q || aw_ready_i) && (!wValid_q || w_ready_i)) begin
          state_d  = WRESP;
          bReady_d = 1'b1;
        end
      end
      WRESP: begin
        if (b_valid_i) begin
          bReady_d    = 1'b0;
          state_d     = RESP;
          respValid_d = 1'b1;
          respErr_d   = (b_resp_i != 2'b00);
          respRd_d    = rd_q;
        end
      end
      RADDR: begin
        if (ar_ready_i) begin
          arValid_d = 1'b0;
          rReady_d  = 1'b1;
          state_d   = RDATA;
        end
      end
      RDATA: begin
        if (r_valid_i) begin
          rReady_d    = 1'b0;
          state_d     = RESP;
          respValid_d = 1'b1;
          respErr_d   = (r_resp_i != 2'b00);
          respWe_d    = (r_resp_i == 2'b00);
          respRdata_d = loadData;
          respRd_d    = rd_q;
        end
      end
      ERR: begin
        state_d     = RESP;
        respValid_d = 1'b1;
        respErr_d   = 1'b1;
        respRd_d    = rd_q;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Registered so that req_ready stays low while reset is held.
    reqReady_d = (state_d == IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      reqReady_q   <= 1'b0;
      awValid_q    <= 1'b0;
      wValid_q     <= 1'b0;
      bReady_q     <= 1'b0;
      arValid_q    <= 1'b0;
      rReady_q     <= 1'b0;
      awAddr_q     <= '0;
      arAddr_q     <= '0;
      wData_q      <= '0;
      wStrb_q      <= '0;
      size_q       <= '0;
      isUnsigned_q <= 1'b0;
      offset_q     <= '0;
      rd_q         <= '0;
      respValid_q  <= 1'b0;
      respWe_q     <= 1'b0;
      respErr_q    <= 1'b0;
      respRdata_q  <= '0;
      respRd_q     <= '0;
    end else begin
      state_q      <= state_d;
      reqReady_q   <= reqReady_d;
      awValid_q    <= awValid_d;
      wValid_q     <= wValid_d;
      bReady_q     <= bReady_d;
      arValid_q    <= arValid_d;
      rReady_q     <= rReady_d;
      awAddr_q     <= awAddr_d;
      arAddr_q     <= arAddr_d;
      wData_q      <= wData_d;
      wStrb_q      <= wStrb_d;
      size_q       <= size_d;
      isUnsigned_q <= isUnsigned_d;
      offset_q     <= offset_d;
      rd_q         <= rd_d;
      respValid_q  <= respValid_d;
      respWe_q     <= respWe_d;
      respErr_q    <= respErr_d;
      respRdata_q  <= respRdata_d;
      respRd_q     <= respRd_d;
    end
  end

  assign req_ready_o  = reqReady_q;
  assign busy_o       = (state_q != IDLE) || (req_valid_i && reqReady_q);
  assign aw_valid_o   = awValid_q;
  assign aw_addr_o    = awAddr_q;
  assign w_valid_o    = wValid_q;
  assign w_data_o     = wData_q;
  assign w_strb_o     = wStrb_q;
  assign b_ready_o    = bReady_q;
  assign ar_valid_o   = arValid_q;
  assign ar_addr_o    = arAddr_q;
  assign r_ready_o    = rReady_q;
  assign resp_valid_o = respValid_q;
  assign resp_we_o    = respWe_q;
  assign resp_err_o   = respErr_q;
  assign resp_rdata_o = respRdata_q;
  assign resp_rd_o    = respRd_q;

endmodule

// File: tb/tb_lsu_axi_ctrl.sv
// Randomised bench for lsu_axi_ctrl: a 64-bit instance driven against a
// behavioural model with a delay-configurable slave, plus a 32-bit instance.
module tb_lsu_axi_ctrl;

  localparam int DW = 64;
  localparam int AW = 32;
  localparam int RW = 5;

  logic clk = 1'b0;
  logic rstN;
  always #5 clk = ~clk;

  logic          reqValid, reqReady, reqWe, reqUnsigned;
  logic [1:0]    reqSize;
  logic [AW-1:0] reqAddr;
  logic [DW-1:0] reqWdata;
  logic [RW-1:0] reqRd;
  logic          respValid, respWe, respErr, busy;
  logic [RW-1:0] respRd;
  logic [DW-1:0] respRdata;
  logic          awValid, awReady, wValid, wReady, bValid, bReady;
  logic          arValid, arReady, rValid, rReady;
  logic [AW-1:0] awAddr, arAddr;
  logic [DW-1:0] wData, rData;
  logic [7:0]    wStrb;
  logic [1:0]    bResp, rResp;

  logic          s32ReqValid, s32ReqReady, s32ReqWe, s32ReqUnsigned;
  logic [1:0]    s32ReqSize;
  logic [AW-1:0] s32ReqAddr;
  logic [31:0]   s32ReqWdata;
  logic [RW-1:0] s32ReqRd;
  logic          s32RespValid, s32RespWe, s32RespErr, s32Busy;
  logic [RW-1:0] s32RespRd;
  logic [31:0]   s32RespRdata;
  logic          s32AwValid, s32AwReady, s32WValid, s32WReady, s32BValid, s32BReady;
  logic          s32ArValid, s32ArReady, s32RValid, s32RReady;
  logic [AW-1:0] s32AwAddr, s32ArAddr;
  logic [31:0]   s32WData, s32RData;
  logic [3:0]    s32WStrb;
  logic [1:0]    s32BResp, s32RResp;

  int assertCount = 0;
  int failCount   = 0;

  lsu_axi_ctrl #(.AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW), .REG_ADDR_WIDTH(RW)) dut (
    .clk_i(clk), .rst_ni(rstN),
    .req_valid_i(reqValid), .req_ready_o(reqReady), .req_we_i(reqWe),
    .req_size_i(reqSize), .req_unsigned_i(reqUnsigned), .req_addr_i(reqAddr),
    .req_wdata_i(reqWdata), .req_rd_i(reqRd),
    .resp_valid_o(respValid), .resp_we_o(respWe), .resp_rd_o(respRd),
    .resp_rdata_o(respRdata), .resp_err_o(respErr), .busy_o(busy),
    .aw_valid_o(awValid), .aw_ready_i(awReady), .aw_addr_o(awAddr),
    .w_valid_o(wValid), .w_ready_i(wReady), .w_data_o(wData), .w_strb_o(wStrb),
    .b_valid_i(bValid), .b_ready_o(bReady), .b_resp_i(bResp),
    .ar_valid_o(arValid), .ar_ready_i(arReady), .ar_addr_o(arAddr),
    .r_valid_i(rValid), .r_ready_o(rReady), .r_data_i(rData), .r_resp_i(rResp)
  );

  lsu_axi_ctrl #(.AXI_DATA_WIDTH(32), .AXI_ADDR_WIDTH(AW), .REG_ADDR_WIDTH(RW)) dut32 (
    .clk_i(clk), .rst_ni(rstN),
    .req_valid_i(s32ReqValid), .req_ready_o(s32ReqReady), .req_we_i(s32ReqWe),
    .req_size_i(s32ReqSize), .req_unsigned_i(s32ReqUnsigned), .req_addr_i(s32ReqAddr),
    .req_wdata_i(s32ReqWdata), .req_rd_i(s32ReqRd),
    .resp_valid_o(s32RespValid), .resp_we_o(s32RespWe), .resp_rd_o(s32RespRd),
    .resp_rdata_o(s32RespRdata), .resp_err_o(s32RespErr), .busy_o(s32Busy),
    .aw_valid_o(s32AwValid), .aw_ready_i(s32AwReady), .aw_addr_o(s32AwAddr),
    .w_valid_o(s32WValid), .w_ready_i(s32WReady), .w_data_o(s32WData), .w_strb_o(s32WStrb),
    .b_valid_i(s32BValid), .b_ready_o(s32BReady), .b_resp_i(s32BResp),
    .ar_valid_o(s32ArValid), .ar_ready_i(s32ArReady), .ar_addr_o(s32ArAddr),
    .r_valid_i(s32RValid), .r_ready_o(s32RReady), .r_data_i(s32RData), .r_resp_i(s32RResp)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Reference load extraction: shift lane down, keep 8<<size bits, extend.
  function automatic logic [63:0] loadModel(input logic [63:0] bus, input int off,
                                            input int size, input bit uns, input int dw);
    int nb;
    logic [63:0] v, mask;
    nb   = 8 << size;
    v    = bus >> (off * 8);
    mask = (nb == 64) ? '1 : ((64'd1 << nb) - 64'd1);
    v    = v & mask;
    if (!uns && v[nb-1]) v = v | ~mask;
    if (dw == 32) v = v & 64'hFFFF_FFFF;
    return v;
  endfunction

  // One full transaction on the 64-bit instance; the slave readies/valids follow
  // the given delays and every cycle is compared with the protocol model.
  task automatic applyStimulus(input bit we, input int size, input bit uns, input logic [31:0] addr,
                               input logic [63:0] wdata, input logic [4:0] rd,
                               input int awDly, input int wDly, input int bDly,
                               input int arDly, input int rDly,
                               input logic [63:0] busData, input logic [1:0] busResp);
    bit bad, expErr, expWe, expRespNow;
    int off, c, bothCycle, arCycle, doneCycle, respCycle;
    bit awDone, wDone, bDone, arDone, rDone;
    logic [7:0]  expStrb;
    logic [63:0] expWdata, expRdata;
    logic [31:0] expAligned;

    bad        = ((addr & ((32'd1 << size) - 32'd1)) != 0);
    off        = int'(addr % 8);
    expStrb    = 8'(((1 << (1 << size)) - 1) << off);
    expWdata   = wdata << (off * 8);
    expAligned = addr & ~32'h7;
    expErr     = bad || (busResp != 2'b00);
    expWe      = !we && !expErr;
    expRdata   = (bad || we) ? 64'd0 : loadModel(busData, off, size, uns, DW);
    awDone = 0; wDone = 0; bDone = 0; arDone = 0; rDone = 0;
    bothCycle = -1; arCycle = -1; doneCycle = -1; respCycle = -1;

    @(negedge clk);
    checkOutput("req_ready idle", reqReady, 1'b1);
    reqValid = 1'b1; reqWe = we; reqSize = 2'(size); reqUnsigned = uns;
    reqAddr = addr; reqWdata = wdata; reqRd = rd;
    #1 checkOutput("busy on accept", busy, 1'b1);
    @(negedge clk);
    reqValid = 1'b0; reqAddr = $urandom; reqWdata = {$urandom, $urandom}; reqRd = 5'($urandom);
    c = 1;
    forever begin
      if (respCycle >= 0) begin
        checkOutput("req_ready after resp", reqReady, 1'b1);
        checkOutput("busy after resp", busy, 1'b0);
        checkOutput("resp_valid single pulse", respValid, 1'b0);
        break;
      end
      if (c > 40) begin
        checkOutput("transaction timeout", 64'd0, 64'd1);
        break;
      end
      expRespNow = bad ? (c == 2) : (doneCycle >= 0 && c == doneCycle + 1);
      checkOutput("aw_valid", awValid, we && !bad && !awDone);
      checkOutput("w_valid", wValid, we && !bad && !wDone);
      checkOutput("ar_valid", arValid, !we && !bad && !arDone);
      checkOutput("b_ready", bReady, we && !bad && bothCycle >= 0 && c > bothCycle && !bDone);
      checkOutput("r_ready", rReady, !we && !bad && arCycle >= 0 && c > arCycle && !rDone);
      checkOutput("resp_valid", respValid, expRespNow);
      checkOutput("busy in flight", busy, 1'b1);
      if (awValid) checkOutput("aw_addr", awAddr, expAligned);
      if (wValid) begin
        checkOutput("w_data", wData, expWdata);
        checkOutput("w_strb", wStrb, expStrb);
      end
      if (arValid) checkOutput("ar_addr", arAddr, expAligned);
      if (expRespNow) begin
        checkOutput("resp_err", respErr, expErr);
        checkOutput("resp_we", respWe, expWe);
        checkOutput("resp_rd", respRd, rd);
        checkOutput("resp_rdata", respRdata, expRdata);
        respCycle = c;
      end else begin
        checkOutput("resp_rdata idle", respRdata, 64'd0);
        checkOutput("resp flags idle", {respWe, respErr, respRd}, 64'd0);
      end

      awReady = (c > awDly);
      wReady  = (c > wDly);
      arReady = (c > arDly);
      bValid  = (bothCycle >= 0) && (c > bothCycle + bDly) && !bDone;
      bResp   = bValid ? busResp : 2'($urandom);
      rValid  = (arCycle >= 0) && (c > arCycle + rDly) && !rDone;
      rData   = rValid ? busData : {$urandom, $urandom};
      rResp   = rValid ? busResp : 2'($urandom);

      if (awValid && awReady) awDone = 1;
      if (wValid && wReady) wDone = 1;
      if (awDone && wDone && bothCycle < 0) bothCycle = c;
      if (arValid && arReady) begin arDone = 1; arCycle = c; end
      if (bValid && bReady) begin bDone = 1; doneCycle = c; end
      if (rValid && rReady) begin rDone = 1; doneCycle = c; end
      @(negedge clk);
      c++;
    end
    awReady = 0; wReady = 0; arReady = 0; bValid = 0; rValid = 0; bResp = 0; rResp = 0;
  endtask

  // Zero-wait load on the 32-bit instance.
  task automatic applyStimulus32(input int size, input bit uns, input logic [31:0] addr,
                                 input logic [31:0] busData, input bit expErr,
                                 input logic [31:0] expRdata);
    bit arSeen, rDone, gotResp;
    int arCount;
    arSeen = 0; rDone = 0; gotResp = 0; arCount = 0;
    @(negedge clk);
    checkOutput("32 req_ready", s32ReqReady, 1'b1);
    s32ReqValid = 1'b1; s32ReqWe = 1'b0; s32ReqSize = 2'(size); s32ReqUnsigned = uns;
    s32ReqAddr = addr; s32ReqRd = 5'd9;
    @(negedge clk);
    s32ReqValid = 1'b0; s32ReqAddr = $urandom;
    for (int c = 1; c <= 20 && !gotResp; c++) begin
      if (s32RespValid) begin
        checkOutput("32 resp_err", s32RespErr, expErr);
        checkOutput("32 resp_we", s32RespWe, !expErr);
        checkOutput("32 resp_rdata", s32RespRdata, expRdata);
        checkOutput("32 resp_rd", s32RespRd, 5'd9);
        checkOutput("32 latency", c, expErr ? 2 : 3);
        gotResp = 1;
      end
      if (s32ArValid) begin
        arCount++;
        checkOutput("32 ar_addr", s32ArAddr, addr & ~32'h3);
      end
      s32ArReady = 1'b1;
      s32RValid  = arSeen && !rDone;
      s32RData   = busData;
      if (s32ArValid) arSeen = 1;
      if (s32RValid && s32RReady) rDone = 1;
      @(negedge clk);
    end
    if (!gotResp) checkOutput("32 resp timeout", 64'd0, 64'd1);
    checkOutput("32 ar activity", arCount, expErr ? 0 : 1);
    s32ArReady = 1'b0; s32RValid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int size;
    logic [31:0] addr;
    rstN = 1'b1;
    reqValid = 0; reqWe = 0; reqSize = 0; reqUnsigned = 0; reqAddr = 0; reqWdata = 0; reqRd = 0;
    awReady = 0; wReady = 0; bValid = 0; bResp = 0; arReady = 0; rValid = 0; rData = 0; rResp = 0;
    s32ReqValid = 0; s32ReqWe = 0; s32ReqSize = 0; s32ReqUnsigned = 0; s32ReqAddr = 0;
    s32ReqWdata = 0; s32ReqRd = 0; s32AwReady = 0; s32WReady = 0; s32BValid = 0; s32BResp = 0;
    s32ArReady = 0; s32RValid = 0; s32RData = 0; s32RResp = 0;

    #1 rstN = 1'b0;
    #2;
    checkOutput("reset req_ready", reqReady, 1'b0);
    checkOutput("reset busy", busy, 1'b0);
    checkOutput("reset valids", {awValid, wValid, arValid, bReady, rReady, respValid}, 64'd0);
    checkOutput("reset w_strb", wStrb, 8'd0);
    repeat (2) @(negedge clk);
    rstN = 1'b1;

    $display("[TB] directed cases");
    applyStimulus(0, 2, 0, 32'h8000_0004, 64'd0, 5'd7, 0, 0, 0, 0, 0, 64'h8765_4321_0000_0000, 2'b00);
    applyStimulus(1, 0, 0, 32'h8000_0003, 64'hAB, 5'd1, 3, 0, 0, 0, 0, 64'd0, 2'b00);
    applyStimulus(1, 1, 0, 32'h8000_0001, 64'h1234, 5'd2, 0, 0, 0, 0, 0, 64'd0, 2'b00);
    applyStimulus(0, 1, 1, 32'h8000_0006, 64'd0, 5'd3, 0, 0, 0, 0, 0, 64'hF00D_0000_0000_0000, 2'b10);
    applyStimulus(1, 3, 0, 32'h0000_0010, 64'hDEAD_BEEF_CAFE_F00D, 5'd4, 0, 2, 1, 0, 0, 64'd0, 2'b00);
    applyStimulus(0, 3, 0, 32'h0000_0018, 64'd0, 5'd5, 0, 0, 0, 2, 3, 64'h8000_0000_0000_0001, 2'b00);
    applyStimulus(0, 0, 0, 32'h0000_0005, 64'd0, 5'd6, 0, 0, 0, 0, 0, 64'h0000_8000_0000_0000, 2'b00);

    $display("[TB] randomised cases");
    for (int i = 0; i < 40; i++) begin
      size = $urandom_range(0, 3);
      addr = $urandom;
      if ($urandom_range(0, 4) != 0) addr = addr & ~((32'd1 << size) - 32'd1);
      applyStimulus($urandom_range(0, 1), size, $urandom_range(0, 1), addr,
                    {$urandom, $urandom}, 5'($urandom),
                    $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3), $urandom_range(0, 3), {$urandom, $urandom},
                    ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00);
    end

    $display("[TB] 32-bit bus cases");
    applyStimulus32(3, 0, 32'h0000_0000, 32'h1234_5678, 1'b1, 32'd0);
    applyStimulus32(0, 0, 32'h0000_0002, 32'h0080_0000, 1'b0, 32'hFFFF_FF80);
    applyStimulus32(1, 0, 32'h0000_0012, 32'h9ABC_0000, 1'b0, 32'(loadModel(64'h9ABC_0000, 2, 1, 0, 32)));
    applyStimulus32(2, 1, 32'h0000_0104, 32'hCAFE_BABE, 1'b0, 32'hCAFE_BABE);

    $display("[TB] reset during RDATA");
    @(negedge clk);
    reqValid = 1'b1; reqWe = 1'b0; reqSize = 2'd2; reqUnsigned = 1'b0; reqAddr = 32'h100; reqRd = 5'd3;
    @(negedge clk);
    reqValid = 1'b0; arReady = 1'b1;
    @(negedge clk);
    arReady = 1'b0;
    checkOutput("r_ready before reset", rReady, 1'b1);
    #2 rstN = 1'b0;
    #1;
    checkOutput("mid reset req_ready busy", {reqReady, busy}, 64'd0);
    checkOutput("mid reset valids", {awValid, wValid, arValid, bReady, rReady, respValid}, 64'd0);
    checkOutput("mid reset resp", {respWe, respErr, respRd}, 64'd0);
    checkOutput("mid reset resp_rdata", respRdata, 64'd0);
    checkOutput("mid reset w_data", wData, 64'd0);
    checkOutput("mid reset w_strb", wStrb, 8'd0);
    checkOutput("mid reset addrs", {awAddr, arAddr}, 64'd0);
    @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
    checkOutput("req_ready after release", reqReady, 1'b1);
    checkOutput("no resp after reset", respValid, 1'b0);
    applyStimulus(0, 2, 1, 32'h0000_0204, 64'd0, 5'd8, 0, 0, 0, 1, 1, 64'hFEED_FACE_0000_0000, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
